// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over load/ready and
// shifts them out one bit per clock on x, with a one-word holding buffer.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);

  localparam int CNT_W = ($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(WIDTH - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The shifter keeps the bit currently on x at its head position.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   shift_r, shift_s;
  logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [WIDTH-1:0]   hold_data_r, hold_data_s;
  logic               hold_full_r, hold_full_s;
  logic               x_r, x_s;
  logic               x_valid_r, x_valid_s;
  logic               word_done_r, word_done_s;
  logic               ready_r, ready_s;
  logic               accept_s;

  assign accept_s  = load && ready_r;
  assign ready     = ready_r;
  assign x         = x_r;
  assign x_valid   = x_valid_r;
  assign word_done = word_done_r;

  // Next-state, shifter, holding buffer and next output values.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    hold_data_s = hold_data_r;
    hold_full_s = hold_full_r;
    x_valid_s   = 1'b0;
    word_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_s   = data_in;
          bit_cnt_s = {CNT_W{1'b0}};
          state_s   = SHIFT;
          x_valid_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == LAST_CNT) begin
          // End of word: buffered word wins, else bypass, else go idle.
          if (hold_full_r) begin
            shift_s     = hold_data_r;
            hold_full_s = 1'b0;
            bit_cnt_s   = {CNT_W{1'b0}};
            x_valid_s   = 1'b1;
          end else if (accept_s) begin
            shift_s     = data_in;
            bit_cnt_s   = {CNT_W{1'b0}};
            x_valid_s   = 1'b1;
          end else begin
            state_s     = IDLE;
            shift_s     = {WIDTH{1'b0}};
            bit_cnt_s   = {CNT_W{1'b0}};
          end
        end else begin
          shift_s     = advance(shift_r);
          bit_cnt_s   = bit_cnt_r + CNT_W'(1);
          x_valid_s   = 1'b1;
          word_done_s = (bit_cnt_r == PRE_LAST_CNT);
          if (accept_s) begin
            hold_data_s = data_in;
            hold_full_s = 1'b1;
          end else begin
            hold_full_s = hold_full_r;
          end
        end
      end
      default: begin
        state_s     = IDLE;
        shift_s     = {WIDTH{1'b0}};
        bit_cnt_s   = {CNT_W{1'b0}};
        hold_full_s = 1'b0;
      end
    endcase
    if (x_valid_s) begin
      x_s = head_bit(shift_s);
    end else begin
      x_s = 1'b0;
    end
    ready_s = !hold_full_s;
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      shift_r     <= {WIDTH{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      hold_data_r <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
      x_r         <= 1'b0;
      x_valid_r   <= 1'b0;
      word_done_r <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      hold_data_r <= hold_data_s;
      hold_full_r <= hold_full_s;
      x_r         <= x_s;
      x_valid_r   <= x_valid_s;
      word_done_r <= word_done_s;
      ready_r     <= ready_s;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first table of streamed words plus
// hand-written reset-mid-word and LSB-first sequences.
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in, data_l;
  logic       load, load_l;
  logic       ready, x, x_valid, word_done;
  logic       ready_l, x_l, x_valid_l, word_done_l;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       load;
    logic [7:0] data;
    logic       x;
    logic       valid;
    logic       done;
    logic       ready;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready), .x(x), .x_valid(x_valid), .word_done(word_done)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_l), .load(load_l),
    .ready(ready_l), .x(x_l), .x_valid(x_valid_l), .word_done(word_done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_msb(input string tag, input logic ex, input logic ev,
                           input logic ed, input logic er);
    check({tag, "_x"}, x, ex);
    check({tag, "_valid"}, x_valid, ev);
    check({tag, "_done"}, word_done, ed);
    check({tag, "_ready"}, ready, er);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] exp_seq;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    load     = 1'b0;
    data_in  = 8'h00;
    load_l   = 1'b0;
    data_l   = 8'h00;

    // load, data, x, valid, done, ready (outputs after the edge)
    vecs[0]  = '{1'b1, 8'hD0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[24] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[25] = '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[26] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[27] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[28] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[29] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[30] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[31] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[32] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[33] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset values after two cycles held low.
    repeat (2) @(posedge clk);
    #2;
    check_msb("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_lsb_valid", x_valid_l, 1'b0);
    check("reset_lsb_ready", ready_l, 1'b1);
    reset = 1'b1;

    // Single word, buffered back-to-back, ignored loads, bypass on last bit.
    for (int i = 0; i < NV; i++) begin
      load    = vecs[i].load;
      data_in = vecs[i].data;
      tick();
      check_msb($sformatf("row%0d", i), vecs[i].x, vecs[i].valid,
                vecs[i].done, vecs[i].ready);
    end
    load = 1'b0;

    // Reset at bit 3 of 8'hFF with 8'h11 buffered.
    load = 1'b1; data_in = 8'hFF;
    tick();
    data_in = 8'h11;
    tick();
    check("mid_buffered_ready", ready, 1'b0);
    load = 1'b0;
    tick();
    tick();
    check_msb("mid_bit3", 1'b1, 1'b1, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1;
    check_msb("async_reset", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_msb("held_reset", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    load = 1'b1; data_in = 8'h81;
    exp_seq = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0;
      check_msb($sformatf("post_reset_bit%0d", i), exp_seq[7-i], 1'b1,
                (i == 7), 1'b1);
    end
    tick();
    check_msb("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB-first: 8'h0B shifts out as 1,1,0,1,0,0,0,0.
    load_l = 1'b1; data_l = 8'h0B;
    exp_seq = 8'b1101_0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      load_l = 1'b0;
      check($sformatf("lsb_bit%0d_x", i), x_l, exp_seq[7-i]);
      check($sformatf("lsb_bit%0d_valid", i), x_valid_l, 1'b1);
      check($sformatf("lsb_bit%0d_done", i), word_done_l, (i == 7));
    end
    tick();
    check("lsb_idle_x", x_l, 1'b0);
    check("lsb_idle_valid", x_valid_l, 1'b0);
    check("lsb_idle_ready", ready_l, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
